// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the round-robin packet arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package axis_arb_pkg;

    // Two-state packet arbiter: waiting for a request, or holding a grant.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // The rotate-and-mask search runs over two concatenated copies of the request vector.
    function automatic int search_width(input int num_ports);
        return 2 * num_ports;
    endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// Round-robin pick: first set request strictly after last_grant, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module rr_priority_encoder
    import axis_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PORT_BITS = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_BITS-1:0] last_grant,
    output logic                 found,
    output logic [PORT_BITS-1:0] grant
);

    localparam int SW = search_width(NUM_PORTS);

    logic [SW-1:0]        req_dbl;
    logic [PORT_BITS:0]   start;
    logic [NUM_PORTS-1:0] rot;
    logic [PORT_BITS-1:0] offset;
    logic [PORT_BITS:0]   sum;

    // Rotating the doubled vector right by last_grant+1 puts the highest-priority port at bit 0.
    assign start   = {1'b0, last_grant} + (PORT_BITS + 1)'(1);
    assign req_dbl = {req, req};
    assign rot     = NUM_PORTS'(req_dbl >> start);

    // Lowest set bit of the rotated vector, then map the offset back to a port number.
    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found  = 1'b1;
                offset = PORT_BITS'(i);
            end
        end
        sum = start + {1'b0, offset};
        if (sum >= (PORT_BITS + 1)'(NUM_PORTS)) begin
            sum = sum - (PORT_BITS + 1)'(NUM_PORTS);
        end
        grant = sum[PORT_BITS-1:0];
    end

endmodule

// File: rtl/axis_rr_packet_arbiter.sv
// Packet-granular round-robin arbiter muxing NUM_PORTS AXI-Stream sources onto one sink.
// Latency: one IDLE cycle to grant, then beats pass combinationally; one bubble between packets.
// Backpressure: m_tready is routed straight to the granted port's s_tready; others see 0.
module axis_rr_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int PORT_BITS  = $clog2(NUM_PORTS),
    parameter int MAX_BEATS  = 256
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            port_enable,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_PORTS-1:0]            s_tvalid,
    input  logic [NUM_PORTS-1:0]            s_tlast,
    output logic [NUM_PORTS-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]           m_tdata,
    output logic                            m_tvalid,
    output logic                            m_tlast,
    output logic [PORT_BITS-1:0]            m_tid,
    input  logic                            m_tready,
    output logic                            busy,
    output logic [PORT_BITS-1:0]            grant_index,
    output logic                            truncated
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    arb_state_t           state;
    logic [CNT_W-1:0]     beat_count;
    logic [NUM_PORTS-1:0] req;
    logic                 enc_found;
    logic [PORT_BITS-1:0] enc_grant;
    logic                 forced_last;
    logic                 beat_fire;

    // Enable mask only matters while choosing the next packet.
    assign req = s_tvalid & port_enable;

    rr_priority_encoder #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_BITS (PORT_BITS)
    ) u_pick (
        .req        (req),
        .last_grant (grant_index),
        .found      (enc_found),
        .grant      (enc_grant)
    );

    assign busy        = (state == ST_BUSY);
    assign forced_last = (beat_count == CNT_W'(MAX_BEATS - 1));
    assign m_tdata     = s_tdata[grant_index*DATA_WIDTH +: DATA_WIDTH];
    assign m_tvalid    = busy & s_tvalid[grant_index];
    assign m_tlast     = s_tlast[grant_index] | forced_last;
    assign m_tid       = grant_index;
    assign beat_fire   = m_tvalid & m_tready;

    // Only the granted port sees downstream ready; nobody is ready while idle.
    always_comb begin
        s_tready = '0;
        if (busy) begin
            s_tready[grant_index] = m_tready;
        end
    end

    // Grant on the idle edge, count beats, release on the accepted (possibly forced) last beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            grant_index <= PORT_BITS'(NUM_PORTS - 1);
            beat_count  <= '0;
            truncated   <= 1'b0;
        end else begin
            truncated <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enc_found) begin
                        grant_index <= enc_grant;
                        state       <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (beat_fire) begin
                        if (m_tlast) begin
                            state      <= ST_IDLE;
                            beat_count <= '0;
                            truncated  <= ~s_tlast[grant_index];
                        end else begin
                            beat_count <= beat_count + CNT_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Scoreboard bench: packet-level reference model predicts each accepted beat and per-cycle controls.
// Latency: n/a.
// Backpressure: sources hold valid until accepted; m_tready is always-on, toggling or random.
module tb_axis_rr_packet_arbiter;

    localparam int NP = 4;
    localparam int DW = 8;
    localparam int PB = 2;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NP-1:0]     port_enable;
    logic [NP*DW-1:0]  s_tdata;
    logic [NP-1:0]     s_tvalid;
    logic [NP-1:0]     s_tlast;
    logic [NP-1:0]     s_tready;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid;
    logic              m_tlast;
    logic [PB-1:0]     m_tid;
    logic              m_tready;
    logic              busy;
    logic [PB-1:0]     grant_index;
    logic              truncated;

    axis_rr_packet_arbiter #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (DW),
        .MAX_BEATS  (MB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .port_enable (port_enable),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tlast     (s_tlast),
        .s_tready    (s_tready),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tlast     (m_tlast),
        .m_tid       (m_tid),
        .m_tready    (m_tready),
        .busy        (busy),
        .grant_index (grant_index),
        .truncated   (truncated)
    );

    always #5 clk = ~clk;

    typedef logic [DW:0] beat_t;   // {last, data}
    typedef struct packed {
        logic [PB-1:0] tid;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    beat_t   srcq [NP][$];
    exp_t    expq [$];
    bit [NP-1:0] showing;
    logic [NP-1:0] acc;
    int      valid_pct;
    int      ready_mode;
    int      vectors = 0;
    int      miscompares = 0;

    // reference model state (packet level)
    bit      mbusy;
    int      mgrant;
    int      mcnt;
    bit      pend_trunc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_pkt(input int port, input int len, input int base);
        for (int b = 0; b < len; b++) begin
            srcq[port].push_back({(b == len - 1), DW'(base + b)});
        end
    endtask

    // Advance one clock: retire accepted beats, then drive the next source/sink state.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (acc[i]) begin
                srcq[i].delete(0);
                showing[i] = 1'b0;
            end
            if (!showing[i] && srcq[i].size() > 0 && $urandom_range(99) < valid_pct) begin
                showing[i] = 1'b1;
            end
            s_tvalid[i] = showing[i];
            if (showing[i]) begin
                s_tdata[i*DW +: DW] = srcq[i][0][DW-1:0];
                s_tlast[i]          = srcq[i][0][DW];
            end else begin
                s_tdata[i*DW +: DW] = DW'($urandom);
                s_tlast[i]          = 1'($urandom);
            end
        end
        case (ready_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'($urandom_range(1));
        endcase
    endtask

    function automatic bit pending();
        bit p;
        p = mbusy;
        for (int i = 0; i < NP; i++) begin
            if (srcq[i].size() > 0) p = 1'b1;
        end
        return p;
    endfunction

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            step();
            n++;
        end
        if (pending()) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: traffic still pending after %0d cycles", budget);
        end
    endtask

    // Reference model: decides at each pre-edge what the DUT must show now and accept at the edge.
    initial begin
        logic [NP-1:0] req;
        logic [NP-1:0] exp_rdy;
        bit            exp_trunc;
        bit            lst;
        bit            forced;
        int            p;
        mbusy      = 1'b0;
        mgrant     = NP - 1;
        mcnt       = 0;
        pend_trunc = 1'b0;
        acc        = '0;
        forever begin
            @(negedge clk);
            exp_trunc  = pend_trunc;
            pend_trunc = 1'b0;
            acc        = '0;
            if (!reset) begin
                mbusy  = 1'b0;
                mgrant = NP - 1;
                mcnt   = 0;
                expq.delete();
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
                chk("rst_s_tready", 32'(s_tready), 32'd0);
                chk("rst_truncated", 32'(truncated), 32'd0);
                chk("rst_grant_index", 32'(grant_index), 32'(NP - 1));
            end else begin
                exp_rdy = '0;
                if (mbusy) exp_rdy[mgrant] = m_tready;
                chk("busy", 32'(busy), 32'(mbusy));
                chk("grant_index", 32'(grant_index), 32'(mgrant));
                chk("m_tvalid", 32'(m_tvalid), 32'(mbusy && s_tvalid[mgrant]));
                chk("s_tready", 32'(s_tready), 32'(exp_rdy));
                chk("truncated", 32'(truncated), 32'(exp_trunc));
                if (!mbusy) begin
                    req = s_tvalid & port_enable;
                    for (int k = 1; k <= NP; k++) begin
                        p = (mgrant + k) % NP;
                        if (req[p] && !mbusy) begin
                            mbusy  = 1'b1;
                            mgrant = p;
                        end
                    end
                end else if (s_tvalid[mgrant] && m_tready) begin
                    lst    = s_tlast[mgrant];
                    forced = (mcnt == MB - 1);
                    expq.push_back('{tid: PB'(mgrant), data: s_tdata[mgrant*DW +: DW], last: (lst || forced)});
                    acc[mgrant] = 1'b1;
                    if (lst || forced) begin
                        mbusy      = 1'b0;
                        mcnt       = 0;
                        pend_trunc = !lst;
                    end else begin
                        mcnt++;
                    end
                end
            end
        end
    end

    // Monitor: every beat the DUT hands downstream must match the next predicted beat.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (reset && m_tvalid && m_tready) begin
                if (expq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_beat: tid %0d data %0h with nothing predicted", m_tid, m_tdata);
                end else begin
                    e = expq.pop_front();
                    chk("m_tid", 32'(m_tid), 32'(e.tid));
                    chk("m_tdata", 32'(m_tdata), 32'(e.data));
                    chk("m_tlast", 32'(m_tlast), 32'(e.last));
                end
            end
        end
    end

    initial begin
        int n;
        port_enable = '1;
        s_tvalid    = '0;
        s_tdata     = '0;
        s_tlast     = '0;
        m_tready    = 1'b0;
        showing     = '0;
        valid_pct   = 100;
        ready_mode  = 0;
        repeat (3) step();
        reset = 1'b1;

        // single port, three 3-beat packets
        for (int k = 0; k < 3; k++) add_pkt(0, 3, 0);
        drain(200);

        // fairness: every port offers 2-beat packets continuously
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < NP; p++) add_pkt(p, 2, p * 16);
        end
        drain(300);

        // backpressure: toggling ready on a 4-beat packet from port 2
        ready_mode = 1;
        add_pkt(2, 4, 32);
        drain(200);
        ready_mode = 0;

        // mask: only ports 1 and 3, then re-enable port 0 while 3 holds the grant
        port_enable = 4'b1010;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < NP; p++) add_pkt(p, 2, p * 16 + 8);
        end
        n = 0;
        while (!(mbusy && mgrant == 3) && n < 100) begin
            step();
            n++;
        end
        if (!(mbusy && mgrant == 3)) begin
            vectors++;
            miscompares++;
            $display("FAIL mask_wait: port 3 never granted within %0d cycles", n);
        end
        port_enable = 4'b1011;
        repeat (8) step();
        port_enable = '1;
        drain(300);

        // truncation: 6-beat packet cut at MAX_BEATS
        add_pkt(1, 6, 16);
        drain(200);

        // reset during beat 2 of a port-0 packet
        add_pkt(0, 4, 64);
        for (int p = 1; p < NP; p++) add_pkt(p, 2, p * 16 + 64);
        n = 0;
        while (!(mbusy && mgrant == 0 && mcnt == 1) && n < 100) begin
            step();
            n++;
        end
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_s_tready", 32'(s_tready), 32'd0);
        step();
        step();
        reset = 1'b1;
        step();
        chk("post_rst_busy", 32'(busy), 32'd1);
        chk("post_rst_grant", 32'(grant_index), 32'd0);
        drain(300);

        // randomized traffic with random valid gaps, backpressure and mask changes
        ready_mode = 2;
        for (int c = 0; c < 600; c++) begin
            if (c % 100 == 0) valid_pct = $urandom_range(100, 30);
            if ($urandom_range(5) == 0) begin
                n = $urandom_range(NP - 1);
                if (srcq[n].size() < 8) add_pkt(n, $urandom_range(6, 1), $urandom_range(255));
            end
            if ($urandom_range(24) == 0) port_enable = NP'($urandom);
            step();
        end
        port_enable = '1;
        valid_pct   = 100;
        ready_mode  = 0;
        drain(3000);
        repeat (3) step();
        chk("scoreboard_empty", 32'(expq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_rr_packet_arbiter.md
Name: axis_rr_packet_arbiter

Overview:
Round-robin, packet-granular arbiter that shares one AXI-Stream sink, typically the sink of axis_async_fifo_wrapper, between NUM_PORTS requesting streams. Once a port is granted, it holds the grant until its tlast beat is accepted, so packets are never interleaved. The source index is forwarded on m_tid. A per-port enable mask and a beat counter provide software control and observability.

Parameters:
NUM_PORTS, 4, number of requesting sink ports (2..16)
DATA_WIDTH, 8, tdata width per port
PORT_BITS, $clog2(NUM_PORTS), width of the grant index and m_tid (derived; do not override)
MAX_BEATS, 256, beat limit per packet; reaching it forces packet termination

Ports:
clk  in  1  single clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
port_enable  in  NUM_PORTS  per-port arbitration mask; 1 = eligible
s_tdata  in  NUM_PORTS*DATA_WIDTH  port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
s_tvalid  in  NUM_PORTS  per-port valid
s_tlast  in  NUM_PORTS  per-port last
s_tready  out  NUM_PORTS  per-port ready
m_tdata  out  DATA_WIDTH  arbitrated data
m_tvalid  out  1  arbitrated valid
m_tlast  out  1  arbitrated last (includes forced last)
m_tid  out  PORT_BITS  index of the granted port
m_tready  in  1  downstream ready
busy  out  1  a grant is held
grant_index  out  PORT_BITS  current or most recent grant
truncated  out  1  one-cycle pulse when a packet is cut at MAX_BEATS

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, grant_index=NUM_PORTS-1 (so port 0 has first priority), beat_count=0, truncated=0, s_tready=0, m_tvalid=0.
- States: IDLE, BUSY.
- IDLE:
  - Outputs: m_tvalid=0, s_tready=0.
  - Arbitration: req = s_tvalid & port_enable. If req≠0, choose the first set bit searching from grant_index+1 upward, wrapping modulo NUM_PORTS. Register it into grant_index and go to BUSY on the same edge.
  - Latency: one cycle from request to first possible transfer.
- BUSY (g = grant_index), combinational path:
  - m_tdata/m_tvalid/m_tlast/m_tid are taken from port g.
  - s_tready[g] = m_tready; all other s_tready are 0.
- Beat accounting: on each beat where m_tvalid && m_tready, beat_count increments.
- Forced last: m_tlast = s_tlast[g] | (beat_count == MAX_BEATS-1).
- End of packet: on an accepted beat with m_tlast=1, go to IDLE and clear beat_count.
  - If the end was forced (s_tlast[g]=0), pulse truncated for one cycle.
  - The rest of the source packet is arbitrated later as a new packet.
- No back-to-back grant: at least one IDLE cycle separates packets. This is accepted and documented as one bubble cycle per packet.
- port_enable:
  - Sampled only in IDLE.
  - Deasserting the enable of the granted port in BUSY does not abort the packet.
- Dropped valid: if s_tvalid[g] drops mid-packet, stay in BUSY with m_tvalid=0. There is no timeout.
- Single requester: that port is re-granted after each IDLE cycle.
- Reset mid-packet: immediate return to the reset values. Any partial packet downstream is the system's responsibility.
- beat_count width: $clog2(MAX_BEATS+1). Saturation is unnecessary because termination occurs at MAX_BEATS-1.
- busy = (state == BUSY).

Decomposition:
- Package axis_arb_pkg holds:
  - the state enum type (IDLE, BUSY) used by this block;
  - a localparam function computing the next-grant search width.
- Sub-module rr_priority_encoder (purely combinational).
  - Parameter: NUM_PORTS.
  - Inputs: req, last_grant.
  - Outputs: found, grant.
  - Implemented as double-width rotate-and-mask.

Test Plan:
1. Single port: port 0 sends 3-beat packets (tdata 0,1,2; tlast on 2), m_tready=1. Required: m_tdata 0,1,2, m_tid=0, m_tlast on beat 3, first m_tvalid one cycle after s_tvalid.
2. Fairness: ports 0–3 each continuously offer 2-beat packets with tdata = port*16 + beat. Required: m_tid sequence 0,1,2,3,0…, with no interleaving inside any packet.
3. Backpressure: m_tready toggles every cycle during a 4-beat packet on port 2. Required: all 4 beats delivered in order, s_tready[2] mirrors m_tready, and s_tready of the other ports stays 0.
4. Mask: port_enable=4'b1010 with all ports valid. Required: only ports 1 and 3 are granted, alternating. Asserting port_enable[0] while port 3 is busy → port 0 is granted next (search wraps from 3).
5. Truncation: MAX_BEATS=4, port 1 sends a 6-beat packet. Required: m_tlast on beat 4, one truncated pulse, then beats 5–6 delivered as a new grant with m_tlast on beat 6.
6. Reset mid-packet: assert reset during beat 2 of port 0. Required: m_tvalid=0, busy=0 and s_tready=0 immediately (asynchronous). After release, port 0 has priority again.
